// File: rtl/mgt_01_fp_round_unit_pkg.sv
// Shared types and constants for the FPU rounding stage.
package mgt_01_fp_round_unit_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } round_mode_e;

  // Accrued / per-op exception flags, MSB first: NV DZ OF UF NX.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    VALID = 2'b10
  } round_state_e;

  localparam logic [31:0] CANO_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] P_INFTY   = 32'h7F80_0000;
  localparam logic [31:0] N_INFTY   = 32'hFF80_0000;
  localparam logic [31:0] MAX_FLOAT = 32'h7F7F_FFFF;

  // Encodings 101, 110 and 111 cannot be used as an effective rounding mode.
  function automatic logic rm_reserved(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
  endfunction

endpackage

// File: rtl/mgt_01_fp_round_decision.sv
// Decides whether the truncated mantissa must be incremented for a rounding mode.
module mgt_01_fp_round_decision
  import mgt_01_fp_round_unit_pkg::*;
(
  input  logic        sign,
  input  logic        lsb,
  input  logic [2:0]  grs,
  input  round_mode_e rm,
  output logic        inc
);

  logic g;
  logic r;
  logic s;

  assign g = grs[2];
  assign r = grs[1];
  assign s = grs[0];

  // Increment rule per rounding mode; reserved modes never increment.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RNE:     inc = g & (r | s | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & (g | r | s);
      RUP:     inc = ~sign & (g | r | s);
      RMM:     inc = g;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/mgt_01_fp_round_unit.sv
// Rounding stage at the end of the FPU: applies the rounding mode, substitutes
// special results, and maintains the accrued fflags register.
module mgt_01_fp_round_unit
  import mgt_01_fp_round_unit_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clk_en_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [EXP_W+MAN_W:0]   to_round_i,
  input  logic [2:0]             grs_i,
  input  logic [2:0]             rm_i,
  input  logic [2:0]             frm_i,
  input  logic                   invalid_op_i,
  input  logic                   div_zero_i,
  input  logic                   overflow_i,
  input  logic                   underflow_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic                   valid_o,
  output logic [4:0]             op_flags_o,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_clr_i,
  output logic                   illegal_rm_o,
  output fu_state_e              fu_state_o
);

  localparam int FP_W = 1 + EXP_W + MAN_W;

  round_state_e      state;
  fflags_t           fflags_q;

  logic [FP_W-1:0]   to_round_p0;
  logic [2:0]        grs_p0;
  logic [2:0]        rm_p0;
  logic              inv_p0;
  logic              dz_p0;
  logic              ovf_p0;
  logic              uf_p0;

  logic              sign_p0;
  logic [EXP_W-1:0]  exp_p0;
  logic [MAN_W-1:0]  man_p0;
  logic              inc_p0;
  logic [FP_W-1:0]   sum_p0;
  logic [FP_W-1:0]   rounded_p0;
  logic              is_nan_p0;
  logic              is_inf_p0;
  logic              rnd_ovf_p0;
  logic              reserved_p0;
  logic [FP_W+4:0]   res_p0;

  // Special-case substitution in priority order; returns {flags, value}.
  function automatic logic [FP_W+4:0] resolve(
    input logic [FP_W-1:0] raw,
    input logic [FP_W-1:0] rounded,
    input logic            reserved,
    input logic            is_nan,
    input logic            is_inf,
    input logic            inv,
    input logic            dz,
    input logic            ovf,
    input logic            uf,
    input logic            inexact,
    input logic [2:0]      rm
  );
    fflags_t         fl;
    logic [FP_W-1:0] val;
    logic [FP_W-1:0] inf_s;
    logic [FP_W-1:0] max_s;
    logic            sign;
    sign  = raw[FP_W-1];
    inf_s = sign ? N_INFTY : P_INFTY;
    max_s = {sign, MAX_FLOAT[FP_W-2:0]};
    fl    = '0;
    val   = rounded;
    if (reserved) begin
      val = '0;
    end else if (inv || is_nan) begin
      val   = CANO_NAN;
      fl.nv = inv;
    end else if (dz) begin
      val   = inf_s;
      fl.dz = 1'b1;
    end else if (ovf) begin
      fl.of = 1'b1;
      fl.nx = 1'b1;
      case (rm)
        RTZ:     val = max_s;
        RUP:     val = sign ? max_s : inf_s;
        RDN:     val = sign ? inf_s : max_s;
        default: val = inf_s;
      endcase
    end else if (uf) begin
      fl.uf = 1'b1;
      fl.nx = 1'b1;
      val   = {sign, {(FP_W-1){1'b0}}};
      if ((rm == RUP && !sign) || (rm == RDN && sign)) begin
        val[0] = 1'b1;
      end
    end else if (is_inf) begin
      val = raw;
    end else begin
      fl.nx = inexact;
    end
    return {fl, val};
  endfunction

  assign sign_p0 = to_round_p0[FP_W-1];
  assign exp_p0  = to_round_p0[FP_W-2 -: EXP_W];
  assign man_p0  = to_round_p0[MAN_W-1:0];

  mgt_01_fp_round_decision u_decision (
    .sign (sign_p0),
    .lsb  (man_p0[0]),
    .grs  (grs_p0),
    .rm   (round_mode_e'(rm_p0)),
    .inc  (inc_p0)
  );

  // Mantissa carry-out ripples naturally into the exponent field.
  assign sum_p0      = {1'b0, exp_p0, man_p0} + FP_W'(inc_p0);
  assign rounded_p0  = {sign_p0, sum_p0[FP_W-2:0]};
  assign is_nan_p0   = (&exp_p0) && (|man_p0);
  assign is_inf_p0   = (&exp_p0) && !(|man_p0);
  assign rnd_ovf_p0  = (&sum_p0[FP_W-2 -: EXP_W]) && !(&exp_p0);
  assign reserved_p0 = rm_reserved(rm_p0);

  assign res_p0 = resolve(to_round_p0, rounded_p0, reserved_p0, is_nan_p0, is_inf_p0,
                          inv_p0, dz_p0, ovf_p0 | rnd_ovf_p0, uf_p0, |grs_p0, rm_p0);

  // ---- stage p0: operand capture on accept ----
  always_ff @(posedge clk_i) begin
    if (clk_en_i && state == IDLE && valid_i) begin
      to_round_p0 <= to_round_i;
      grs_p0      <= grs_i;
      rm_p0       <= (rm_i == DYN) ? frm_i : rm_i;
      inv_p0      <= invalid_op_i;
      dz_p0       <= div_zero_i;
      ovf_p0      <= overflow_i;
      uf_p0       <= underflow_i;
    end
  end

  // ---- stage p1: FSM, registered result and accrued flags ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      valid_o      <= 1'b0;
      result_o     <= '0;
      op_flags_o   <= '0;
      illegal_rm_o <= 1'b0;
      fflags_q     <= '0;
    end else if (clk_en_i) begin
      valid_o <= 1'b0;
      if (fflags_clr_i) begin
        fflags_q <= '0;
      end
      case (state)
        IDLE: begin
          if (valid_i) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          state        <= VALID;
          valid_o      <= 1'b1;
          result_o     <= res_p0[FP_W-1:0];
          op_flags_o   <= res_p0[FP_W+4:FP_W];
          illegal_rm_o <= reserved_p0;
          fflags_q     <= (fflags_clr_i ? fflags_t'('0) : fflags_q) | fflags_t'(res_p0[FP_W+4:FP_W]);
        end
        VALID: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o    = (state == IDLE);
  assign fu_state_o = (state == IDLE) ? FREE : BUSY;
  assign fflags_o   = fflags_q;

endmodule

// File: tb/tb_mgt_01_fp_round_unit.sv
// Directed bench for the FPU rounding stage with a queue-based scoreboard.
module tb_mgt_01_fp_round_unit;
  import mgt_01_fp_round_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        clk_en_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] to_round_i;
  logic [2:0]  grs_i;
  logic [2:0]  rm_i;
  logic [2:0]  frm_i;
  logic        invalid_op_i;
  logic        div_zero_i;
  logic        overflow_i;
  logic        underflow_i;
  logic [31:0] result_o;
  logic        valid_o;
  logic [4:0]  op_flags_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;
  logic        illegal_rm_o;
  fu_state_e   fu_state_o;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  fl;
    logic        ill;
    logic [4:0]  ff;
    int          due;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         edge_cnt = 0;
  logic [4:0] ff_m = '0;

  mgt_01_fp_round_unit dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clk_en_i     (clk_en_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .to_round_i   (to_round_i),
    .grs_i        (grs_i),
    .rm_i         (rm_i),
    .frm_i        (frm_i),
    .invalid_op_i (invalid_op_i),
    .div_zero_i   (div_zero_i),
    .overflow_i   (overflow_i),
    .underflow_i  (underflow_i),
    .result_o     (result_o),
    .valid_o      (valid_o),
    .op_flags_o   (op_flags_o),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i),
    .illegal_rm_o (illegal_rm_o),
    .fu_state_o   (fu_state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Bounded wait for the unit to become ready (sampled on the falling edge).
  task automatic wait_ready(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: ready_o stayed 0, expected 1", nm);
    end
  endtask

  // Issue one operation and push its expected response.
  task automatic issue(input string nm, input logic [31:0] v, input logic [2:0] g,
                       input logic [2:0] rm, input logic [2:0] frm, input logic [3:0] exc,
                       input logic clr, input int hold,
                       input logic [31:0] er, input logic [4:0] ef, input logic ei);
    exp_t e;
    wait_ready(nm);
    to_round_i   = v;
    grs_i        = g;
    rm_i         = rm;
    frm_i        = frm;
    {invalid_op_i, div_zero_i, overflow_i, underflow_i} = exc;
    valid_i      = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    if (clr) ff_m = '0;
    ff_m  = ff_m | ef;
    e.name = nm;
    e.res  = er;
    e.fl   = ef;
    e.ill  = ei;
    e.ff   = ff_m;
    e.due  = edge_cnt + 1 + hold;
    sb.push_back(e);
    if (hold > 0) begin
      clk_en_i = 1'b0;
      repeat (hold) @(posedge clk_i);
      #1;
      clk_en_i = 1'b1;
    end
    if (clr) begin
      fflags_clr_i = 1'b1;
      @(posedge clk_i);
      #1;
      fflags_clr_i = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the unit presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (valid_o) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: valid_o=1, expected 0 (nothing pending)");
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, result_o, e.res);
          check({e.name, "_op_flags"}, 32'(op_flags_o), 32'(e.fl));
          check({e.name, "_illegal_rm"}, 32'(illegal_rm_o), 32'(e.ill));
          check({e.name, "_fflags"}, 32'(fflags_o), 32'(e.ff));
          check({e.name, "_latency"}, 32'(edge_cnt), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;  clk_en_i = 1'b1;  valid_i = 1'b0;  to_round_i = '0;
    grs_i = '0;  rm_i = '0;  frm_i = '0;  fflags_clr_i = 1'b0;
    {invalid_op_i, div_zero_i, overflow_i, underflow_i} = '0;
    repeat (3) @(negedge clk_i);
    check("rst_result", result_o, 32'h0);
    check("rst_op_flags", 32'(op_flags_o), 32'h0);
    check("rst_fflags", 32'(fflags_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_illegal", 32'(illegal_rm_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'h1);
    check("rst_fu_state", 32'(fu_state_o), 32'(FREE));
    rst_n_i = 1'b1;

    //     name          value         grs     rm      frm     exc      clr  hold expected      flags     ill
    issue("tie_even",    32'h3F800000, 3'b100, 3'b000, 3'b000, 4'b0000, 0, 0, 32'h3F800000, 5'b00001, 0);
    issue("tie_odd",     32'h3F800001, 3'b100, 3'b000, 3'b000, 4'b0000, 0, 0, 32'h3F800002, 5'b00001, 0);
    issue("rtz_trunc",   32'h3F800001, 3'b100, 3'b001, 3'b000, 4'b0000, 0, 0, 32'h3F800001, 5'b00001, 0);
    issue("carry_exp",   32'h3FFFFFFF, 3'b110, 3'b000, 3'b000, 4'b0000, 0, 0, 32'h40000000, 5'b00001, 0);
    issue("rup_ovf",     32'h7F7FFFFF, 3'b100, 3'b011, 3'b000, 4'b0000, 0, 0, 32'h7F800000, 5'b00101, 0);
    issue("rtz_max",     32'h7F7FFFFF, 3'b100, 3'b001, 3'b000, 4'b0000, 0, 0, 32'h7F7FFFFF, 5'b00001, 0);
    issue("invalid",     32'h3F800000, 3'b000, 3'b000, 3'b000, 4'b1000, 0, 0, 32'h7FC00000, 5'b10000, 0);
    issue("clr_nx",      32'h3F800001, 3'b001, 3'b000, 3'b000, 4'b0000, 1, 0, 32'h3F800001, 5'b00001, 0);
    issue("dyn_resv",    32'h3F800001, 3'b100, 3'b111, 3'b101, 4'b0000, 0, 0, 32'h00000000, 5'b00000, 1);
    issue("div_zero",    32'hBF800000, 3'b000, 3'b000, 3'b000, 4'b0100, 0, 0, 32'hFF800000, 5'b01000, 0);
    issue("ovf_rdn_pos", 32'h3F800000, 3'b000, 3'b010, 3'b000, 4'b0010, 0, 0, 32'h7F7FFFFF, 5'b00101, 0);
    issue("ovf_rdn_neg", 32'hBF800000, 3'b000, 3'b010, 3'b000, 4'b0010, 0, 0, 32'hFF800000, 5'b00101, 0);
    issue("ovf_rtz_neg", 32'hBF800000, 3'b000, 3'b001, 3'b000, 4'b0010, 0, 0, 32'hFF7FFFFF, 5'b00101, 0);
    issue("uf_rup_pos",  32'h00000000, 3'b000, 3'b011, 3'b000, 4'b0001, 0, 0, 32'h00000001, 5'b00011, 0);
    issue("uf_rdn_neg",  32'h80000000, 3'b000, 3'b010, 3'b000, 4'b0001, 0, 0, 32'h80000001, 5'b00011, 0);
    issue("uf_rne_neg",  32'h80000000, 3'b000, 3'b000, 3'b000, 4'b0001, 0, 0, 32'h80000000, 5'b00011, 0);
    issue("nan_in",      32'h7FC00001, 3'b000, 3'b000, 3'b000, 4'b0000, 0, 0, 32'h7FC00000, 5'b00000, 0);
    issue("inf_in",      32'hFF800000, 3'b000, 3'b000, 3'b000, 4'b0000, 0, 0, 32'hFF800000, 5'b00000, 0);
    issue("rmm_tie",     32'h3F800000, 3'b100, 3'b100, 3'b000, 4'b0000, 0, 0, 32'h3F800001, 5'b00001, 0);
    issue("rdn_neg",     32'hBF800000, 3'b001, 3'b010, 3'b000, 4'b0000, 0, 0, 32'hBF800001, 5'b00001, 0);
    issue("rup_pos",     32'h3F800000, 3'b001, 3'b011, 3'b000, 4'b0000, 0, 0, 32'h3F800001, 5'b00001, 0);
    issue("dyn_rup",     32'h3F800000, 3'b010, 3'b111, 3'b011, 4'b0000, 0, 0, 32'h3F800001, 5'b00001, 0);
    issue("exact",       32'h3F800000, 3'b000, 3'b000, 3'b000, 4'b0000, 0, 0, 32'h3F800000, 5'b00000, 0);
    issue("clk_en_hold", 32'h3F800001, 3'b100, 3'b000, 3'b000, 4'b0000, 0, 3, 32'h3F800002, 5'b00001, 0);

    // Reset while the operation is in ROUND: no result may ever appear.
    wait_ready("mid_rst");
    to_round_i = 32'h3F800001;  grs_i = 3'b100;  rm_i = 3'b000;
    {invalid_op_i, div_zero_i, overflow_i, underflow_i} = '0;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    check("mid_rst_busy", 32'(fu_state_o), 32'(BUSY));
    rst_n_i = 1'b0;
    #1;
    ff_m = '0;
    check("mid_rst_ready", 32'(ready_o), 32'h1);
    check("mid_rst_result", result_o, 32'h0);
    check("mid_rst_op_flags", 32'(op_flags_o), 32'h0);
    check("mid_rst_fflags", 32'(fflags_o), 32'h0);
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);

    issue("after_rst",   32'h3FFFFFFF, 3'b110, 3'b000, 3'b000, 4'b0000, 0, 0, 32'h40000000, 5'b00001, 0);
    wait_ready("drain");
    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
